quadrature_downconverter: RTL and testbench



---
 rtl/sdr_pkg.sv | 27 ++
 rtl/cic_decimator.sv | 72 +++++++
 rtl/quadrature_downconverter.sv | 100 ++++++++++
 tb/tb_quadrature_downconverter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// sdr_pkg: shared definitions for the receive-chain blocks.
//   mix_width() - full-precision width of an ADC x LO product.
//   reg_width() - CIC register width, sized so that the DC gain R^N
//                 never overflows the comb output.
//   Default widths and sample typedefs used by the NCO/mixer datapath.
package sdr_pkg;

  localparam int ADC_WIDTH_DEF  = 8;
  localparam int LO_WIDTH_DEF   = 7;
  localparam int CIC_STAGES_DEF = 3;
  localparam int DECIMATION_DEF = 4096;
  localparam int OUT_WIDTH_DEF  = 12;

  typedef logic signed [ADC_WIDTH_DEF-1:0] adc_sample_t;
  typedef logic signed [LO_WIDTH_DEF-1:0]  lo_sample_t;

  function automatic int mix_width(input int adc_w, input int lo_w);
    return adc_w + lo_w;
  endfunction

  // Bit growth of an N-stage CIC with ratio R is N*log2(R).
  function automatic int reg_width(input int adc_w, input int lo_w,
                                   input int stages, input int decim);
    return adc_w + lo_w + stages * $clog2(decim);
  endfunction

endpackage

// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator for one mixer path.
//   clk, arst   - clock, asynchronous active-high reset
//   ce          - input-rate enable; integrators advance only when high
//   dec_strobe  - one-clk decimation strobe; combs and output update on it
//   mix_in      - signed mixer product (MIX_WIDTH)
//   dout        - signed decimated output, top OUT_WIDTH bits of the comb
// Optional macro OUTPUT_ROUNDING_EN: round-half-up before slicing the
// output instead of plain truncation.
module cic_decimator
  import sdr_pkg::*;
#(
  parameter int MIX_WIDTH = 15,
  parameter int REG_WIDTH = 51,
  parameter int STAGES    = 3,
  parameter int OUT_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        ce,
  input  logic                        dec_strobe,
  input  logic signed [MIX_WIDTH-1:0] mix_in,
  output logic signed [OUT_WIDTH-1:0] dout
);

  logic signed [REG_WIDTH-1:0] integ  [STAGES];
  logic signed [REG_WIDTH-1:0] dly    [STAGES];
  logic signed [REG_WIDTH-1:0] comb_c [STAGES+1];
  logic signed [REG_WIDTH-1:0] mix_ext;
  logic signed [REG_WIDTH-1:0] comb_final;

  assign mix_ext = {{(REG_WIDTH-MIX_WIDTH){mix_in[MIX_WIDTH-1]}}, mix_in};

  // Integrators wrap freely: the comb differences cancel the wrap as long
  // as REG_WIDTH covers the full filter gain.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (ce) begin
      integ[0] <= integ[0] + mix_ext;
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Comb chain is combinational within the decimation cycle.
  always_comb begin
    comb_c[0] = integ[STAGES-1];
    for (int k = 1; k <= STAGES; k++) comb_c[k] = comb_c[k-1] - dly[k-1];
  end

`ifdef OUTPUT_ROUNDING_EN
  if (REG_WIDTH > OUT_WIDTH) begin : g_round
    localparam logic signed [REG_WIDTH-1:0] HALF_LSB =
      REG_WIDTH'(1) << (REG_WIDTH-OUT_WIDTH-1);
    assign comb_final = comb_c[STAGES] + HALF_LSB;
  end else begin : g_no_round
    assign comb_final = comb_c[STAGES];
  end
`else
  assign comb_final = comb_c[STAGES];
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < STAGES; k++) dly[k] <= '0;
      dout <= '0;
    end else if (dec_strobe) begin
      for (int k = 0; k < STAGES; k++) dly[k] <= comb_c[k];
      dout <= OUT_WIDTH'(comb_final >>> (REG_WIDTH-OUT_WIDTH));
    end
  end

endmodule

// File: rtl/quadrature_downconverter.sv
// quadrature_downconverter: ADC x NCO mixer followed by CIC decimation on
// the I and Q paths.
//   clk, arst      - clock, asynchronous active-high reset
//   sample_clk_ce  - input-rate enable (same strobe as the NCO)
//   adc_sample     - signed ADC sample, consumed when sample_clk_ce=1
//   lo_cos, lo_sin - signed NCO outputs, consumed on the same ce
//   i_out, q_out   - signed decimated I/Q samples
//   out_valid      - one-clk pulse when i_out/q_out take a new value
// Output handshake: out_valid is a pure strobe with no ready/backpressure;
// the consumer must take i_out/q_out in the cycle out_valid is high (they
// then hold until the next strobe).
// Optional macro OUTPUT_ROUNDING_EN (see cic_decimator).
module quadrature_downconverter
  import sdr_pkg::*;
#(
  parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int LO_WIDTH   = LO_WIDTH_DEF,
  parameter int CIC_STAGES = CIC_STAGES_DEF,
  parameter int DECIMATION = DECIMATION_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        sample_clk_ce,
  input  logic signed [ADC_WIDTH-1:0] adc_sample,
  input  logic signed [LO_WIDTH-1:0]  lo_cos,
  input  logic signed [LO_WIDTH-1:0]  lo_sin,
  output logic signed [OUT_WIDTH-1:0] i_out,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        out_valid
);

  localparam int MIX_WIDTH = mix_width(ADC_WIDTH, LO_WIDTH);
  localparam int REG_WIDTH = reg_width(ADC_WIDTH, LO_WIDTH, CIC_STAGES, DECIMATION);
  localparam int CNT_WIDTH = $clog2(DECIMATION);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DECIMATION-1);

  logic signed [MIX_WIDTH-1:0] adc_ext, cos_ext, sin_ext;
  logic signed [MIX_WIDTH-1:0] mix_i, mix_q;
  logic [CNT_WIDTH-1:0]        dec_count;
  logic                        dec_strobe;

  // Extend both operands to the product width so the multiply is full
  // precision and signed.
  assign adc_ext = {{LO_WIDTH{adc_sample[ADC_WIDTH-1]}}, adc_sample};
  assign cos_ext = {{ADC_WIDTH{lo_cos[LO_WIDTH-1]}}, lo_cos};
  assign sin_ext = {{ADC_WIDTH{lo_sin[LO_WIDTH-1]}}, lo_sin};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mix_i      <= '0;
      mix_q      <= '0;
      dec_count  <= '0;
      dec_strobe <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      dec_strobe <= 1'b0;
      out_valid  <= dec_strobe;
      if (sample_clk_ce) begin
        mix_i <= adc_ext * cos_ext;
        mix_q <= adc_ext * sin_ext;
        if (dec_count == CNT_LAST) begin
          dec_count  <= '0;
          dec_strobe <= 1'b1;
        end else begin
          dec_count <= dec_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  cic_decimator #(
    .MIX_WIDTH (MIX_WIDTH),
    .REG_WIDTH (REG_WIDTH),
    .STAGES    (CIC_STAGES),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_cic_i (
    .clk        (clk),
    .arst       (arst),
    .ce         (sample_clk_ce),
    .dec_strobe (dec_strobe),
    .mix_in     (mix_i),
    .dout       (i_out)
  );

  cic_decimator #(
    .MIX_WIDTH (MIX_WIDTH),
    .REG_WIDTH (REG_WIDTH),
    .STAGES    (CIC_STAGES),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_cic_q (
    .clk        (clk),
    .arst       (arst),
    .ce         (sample_clk_ce),
    .dec_strobe (dec_strobe),
    .mix_in     (mix_q),
    .dout       (q_out)
  );

endmodule

// File: tb/tb_quadrature_downconverter.sv
// Directed bench for quadrature_downconverter. Three instances share the
// stimulus: R=4 full-width (21-bit) output, R=4 12-bit output, and the
// default R=4096 12-bit configuration for the long wrap-around run.
module tb_quadrature_downconverter;

  localparam int N   = 3;
  localparam int R_S = 4;
  localparam int R_B = 4096;

`ifdef OUTPUT_ROUNDING_EN
  localparam int DC_I12 = 79;   // 40320/512 = 78.75 rounded half-up
`else
  localparam int DC_I12 = 78;   // 40320/512 = 78.75 truncated
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  logic               ce;
  logic signed [7:0]  adc;
  logic signed [6:0]  lo_c, lo_s;
  logic signed [20:0] i21, q21;
  logic signed [11:0] i12, q12, ib, qb;
  logic               v21, v12, vb;

  quadrature_downconverter #(
    .ADC_WIDTH(8), .LO_WIDTH(7), .CIC_STAGES(N), .DECIMATION(R_S), .OUT_WIDTH(21)
  ) dut_full (
    .clk(clk), .arst(arst), .sample_clk_ce(ce), .adc_sample(adc),
    .lo_cos(lo_c), .lo_sin(lo_s), .i_out(i21), .q_out(q21), .out_valid(v21)
  );

  quadrature_downconverter #(
    .ADC_WIDTH(8), .LO_WIDTH(7), .CIC_STAGES(N), .DECIMATION(R_S), .OUT_WIDTH(12)
  ) dut_trunc (
    .clk(clk), .arst(arst), .sample_clk_ce(ce), .adc_sample(adc),
    .lo_cos(lo_c), .lo_sin(lo_s), .i_out(i12), .q_out(q12), .out_valid(v12)
  );

  quadrature_downconverter dut_big (
    .clk(clk), .arst(arst), .sample_clk_ce(ce), .adc_sample(adc),
    .lo_cos(lo_c), .lo_sin(lo_s), .i_out(ib), .q_out(qb), .out_valid(vb)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  // Expected outputs for the current phase.
  int exp_i21, exp_q21, exp_i12, exp_q12, exp_ib, exp_qb;
  bit big_check;
  bit alt;

  // Timing model: counts ce's since reset; a strobe is pending after every
  // R-th ce and shows up as out_valid one edge later.
  int ce_s, ce_b, outs_s, outs_b;
  bit pend_s, pend_b;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit ce_v);
    bit ev_s, ev_b;
    ce = ce_v;
    @(posedge clk);
    #1;
    ev_s = pend_s;
    ev_b = pend_b;
    pend_s = 1'b0;
    pend_b = 1'b0;
    if (ce_v) begin
      ce_s++;
      ce_b++;
      if (ce_s % R_S == 0) pend_s = 1'b1;
      if (ce_b % R_B == 0) pend_b = 1'b1;
      if (alt) adc = -adc;
    end
    check("valid_full", v21, ev_s);
    check("valid_trunc", v12, ev_s);
    check("valid_big", vb, ev_b);
    if (ev_s) begin
      outs_s++;
      if (outs_s >= N + 1) begin
        check("i_full", i21, exp_i21);
        check("q_full", q21, exp_q21);
        check("i_trunc", i12, exp_i12);
        check("q_trunc", q12, exp_q12);
      end
    end
    if (ev_b) begin
      outs_b++;
      if (big_check && outs_b >= N + 1) begin
        check("i_big", ib, exp_ib);
        check("q_big", qb, exp_qb);
      end
    end
  endtask

  task automatic run(input int n_clk, input int ce_period);
    for (int t = 0; t < n_clk; t++) tick((t % ce_period) == ce_period - 1);
  endtask

  // Asserts arst between edges, checks the outputs clear at once, then
  // releases after one edge and restarts the timing model.
  task automatic do_reset();
    ce = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    check("rst_i_full", i21, 0);
    check("rst_q_full", q21, 0);
    check("rst_i_trunc", i12, 0);
    check("rst_q_trunc", q12, 0);
    check("rst_i_big", ib, 0);
    check("rst_valid_full", v21, 0);
    check("rst_valid_big", vb, 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    ce_s = 0; ce_b = 0; outs_s = 0; outs_b = 0;
    pend_s = 1'b0; pend_b = 1'b0;
  endtask

  task automatic set_phase(input int a, input int c, input int s,
                           input int ei21, input int eq21,
                           input int ei12, input int eq12);
    adc = 8'(a); lo_c = 7'(c); lo_s = 7'(s);
    exp_i21 = ei21; exp_q21 = eq21; exp_i12 = ei12; exp_q12 = eq12;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ce = 1'b0; adc = '0; lo_c = '0; lo_s = '0;
    alt = 1'b0; big_check = 1'b0;
    exp_ib = 0; exp_qb = 0;
    @(posedge clk);
    #1;
    do_reset();

    // DC on I only: 630 * 4^3 = 40320.
    set_phase(10, 63, 0, 40320, 0, DC_I12, 0);
    run(40, 1);

    // Reset lands while a decimation strobe is pending (40th ce was an
    // R-th ce); the strobe must be dropped and the next out_valid must
    // come after the 4th ce past release.
    do_reset();
    run(24, 1);

    // Extreme product: (-128)*(-64) = 8192, * 64 = 524288, >>9 = 1024.
    do_reset();
    set_phase(-128, -64, -64, 524288, 524288, 1024, 1024);
    run(40, 1);

    // ce on every 3rd clk: same values, out_valid every 12 clks.
    do_reset();
    set_phase(10, 63, 0, 40320, 0, DC_I12, 0);
    run(120, 3);

    // Alternating +-127 input: every CIC tap pair cancels, output 0.
    do_reset();
    set_phase(127, 63, 0, 0, 0, 0, 0);
    alt = 1'b1;
    run(40, 1);
    alt = 1'b0;

    // Long run: integrators wrap in all instances. I: 8192 * R^N,
    // Q: -128*63 = -8064 -> -516096 (R=4); 12-bit slices 1024 / -1008.
    do_reset();
    set_phase(-128, -64, 63, 524288, -516096, 1024, -1008);
    exp_ib = 1024;
    exp_qb = -1008;
    big_check = 1'b1;
    run(6 * R_B + 8, 1);
    check("big_outputs_seen", outs_b, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
